lorenz_frame_streamer: RTL
==========================

# lorenz_frame_streamer

Downstream stage of `lorenz_rk4`. Consumes the Q16.16 state vector (x, y, z) produced each integration step, decimates it by a fixed ratio, and serialises each selected sample into a fixed-length byte frame on a valid/ready byte stream. The byte stream feeds the board UART transmitter for host-side plotting of the attractor.

## Interface

Parameters:
- `DECIM`, 64: decimation ratio. One in every `DECIM` accepted samples is framed. Legal range 1..65535.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: one-cycle strobe; x/y/z hold a new integration step.
- `x` in 32: signed Q16.16.
- `y` in 32: signed Q16.16.
- `z` in 32: signed Q16.16.
- `tx_data` out 8: frame byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts the byte when `tx_valid && tx_ready` is sampled at a clock edge.
- `busy` out 1: a frame is in flight (state != IDLE).
- `drop_count` out 16: selected samples discarded because a frame was in flight. Saturates at 16'hFFFF.

## Operation

- Decimation counter `dcnt` (16 bit):
  - Increments on every `in_valid`.
  - Wraps to 0 after reaching `DECIM-1`.
  - A sample is *selected* when `in_valid && dcnt == DECIM-1`.
  - With `DECIM=1`, every sample is selected.
  - The counter runs regardless of FSM state.
- Capture:
  - A selected sample arriving while the registered state is IDLE is latched into a 96-bit snapshot `{x,y,z}`.
  - A selected sample arriving in any other state is discarded and `drop_count` increments, saturating.
  - This includes the cycle in which the final byte of the previous frame handshakes.
- FSM states and transitions:
  - IDLE → SYNC on capture.
  - SYNC → DATA when the sync byte handshakes; byte index `bidx` resets to 0.
  - DATA (`bidx` 0..11): each handshake advances `bidx`.
  - After `bidx=11` handshakes: go to CSUM if `LORENZ_FRAME_CSUM_EN` is defined, otherwise IDLE.
  - CSUM → IDLE when the checksum byte handshakes.
- Byte order in DATA:
  - x, then y, then z.
  - Each word is sent big-endian, MSB byte first. `bidx=0` is `x[31:24]`; `bidx=11` is `z[7:0]`.
- Snapshot values are sent unmodified (raw two's-complement Q16.16). No rounding or saturation is applied.
- Handshake rules:
  - While `tx_valid=1` and `tx_ready=0`, `tx_data` is held stable and `tx_valid` stays high.
  - `tx_valid` never deasserts mid-frame.
  - The sink may hold `tx_ready` permanently high.
- Reset:
  - Outputs: `tx_valid=0`, `tx_data=0`, `busy=0`, `drop_count=0`.
  - Internal: `dcnt=0`, state IDLE, snapshot and checksum cleared.
  - Reset asserted mid-frame abandons the frame immediately; no partial completion follows reset release.

## Timing

- Capture on edge N: `tx_valid=1` with `tx_data=SYNC_BYTE` from edge N (visible in cycle N+1).
- With `tx_ready` tied high, one byte transfers per cycle.
  - A frame occupies 14 cycles with CSUM, 13 without.
  - `busy` falls on the edge where the last byte handshakes.
- Earliest next capture is on the first cycle after `busy` falls.
- Minimum `DECIM` for zero drops with `tx_ready` high is 15 (CSUM) or 14 (no CSUM), because of the IDLE cycle between frames.
- `tx_data` and `tx_valid` are registered outputs, with no combinational path from `tx_ready`.

## Configuration

- `LORENZ_FRAME_CSUM_EN`:
  - Defined: after the 12 data bytes, a checksum byte is appended. It is the XOR of the 12 data bytes, excluding sync. Frame length is 14 bytes.
  - Undefined: no CSUM state and no checksum logic. Frame length is 13 bytes.

## Test plan

Vector for tests 1 and 2: `x=32'h00010000` (1.0), `y=32'hFFFF0000` (-1.0), `z=32'h00198000` (25.5).

1. Basic frame, `DECIM=1`, `tx_ready=1`, one `in_valid` with the vector above.
   - Required bytes: A5 00 01 00 00 FF FF 00 00 00 19 80 00, then 98 with CSUM_EN.
   - `busy` is high for exactly 14 cycles (13 without CSUM_EN).
2. Backpressure, same vector, `tx_ready` toggled 0/1 pseudo-randomly.
   - Byte sequence is identical to test 1.
   - `tx_data` is stable and `tx_valid` high for every stalled cycle.
3. Decimation, `DECIM=4`, 16 consecutive `in_valid`, `x`=sample index.
   - Exactly 4 frames are produced, with x = 3, 7, 11, 15.
   - `drop_count=0`.
4. Overrun, `DECIM=2`, `tx_ready=0` for 20 cycles with continuous `in_valid`, then `tx_ready=1`.
   - One frame is emitted, carrying the first selected sample.
   - `drop_count=9`.
   - Also verify `drop_count` saturates at FFFF via forced long stall.
5. Reset mid-frame: assert `rst_n=0` after byte 5 handshakes, hold 3 cycles, release.
   - `tx_valid=0`, `busy=0`, `drop_count=0` immediately on assertion.
   - The next capture produces a complete fresh frame starting with A5.
6. Boundary: a selected sample arrives on the same edge the final frame byte handshakes.
   - The sample is dropped and `drop_count` increments by 1.
   - The next selected sample is captured normally.

Source files
------------

// File: rtl/lorenz_frame_streamer.sv
// lorenz_frame_streamer
//
// Decimates the Q16.16 state vector (x, y, z) from lorenz_rk4 and serialises
// each selected sample into a byte frame for the board UART:
//   SYNC_BYTE, x[31:24] .. x[7:0], y[31:24] .. y[7:0], z[31:24] .. z[7:0]
//   [, checksum = XOR of the 12 data bytes]
//
// Optional feature macro: LORENZ_FRAME_CSUM_EN
//   - defined:   a checksum byte is appended (14-byte frame).
//   - undefined: no checksum state or logic (13-byte frame).
//
// Handshake: a byte moves when tx_valid && tx_ready are both high at a rising
// clk edge. Once tx_valid is high it stays high, with tx_data held, until the
// byte is taken. tx_valid stays high for the whole frame. tx_valid and
// tx_data are registered and do not depend combinationally on tx_ready.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   one-cycle strobe, x/y/z hold a new integration step
//   x, y, z    in   32-bit signed Q16.16 state
//   tx_data    out  frame byte
//   tx_valid   out  tx_data valid
//   tx_ready   in   sink accepts the byte
//   busy       out  a frame is in flight (state != IDLE)
//   drop_count out  selected samples lost while busy, saturating at 16'hFFFF
//
// The FSM state is available as the internal signal 'state' (see state_t).
module lorenz_frame_streamer #(
  parameter int unsigned DECIM     = 64,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] drop_count
);

`ifdef LORENZ_FRAME_CSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } state_t;
`endif

  localparam logic [15:0] DCNT_LAST = 16'(DECIM - 1);
  localparam logic [3:0]  LAST_BIDX = 4'd11;

  state_t      state, state_nxt;
  logic [3:0]  bidx, bidx_nxt;
  logic [15:0] dcnt;
  logic [95:0] snap;
  logic [95:0] snap_shift;
  logic [7:0]  tx_data_nxt;
  logic        tx_valid_nxt;
  logic        selected;
  logic        capture;
  logic        drop;
  logic        hs;

`ifdef LORENZ_FRAME_CSUM_EN
  logic [7:0]  csum, csum_nxt;
`endif

  // Selection uses the registered state: a sample that coincides with the
  // last byte of the previous frame still sees a non-IDLE state and is lost.
  assign selected = in_valid && (dcnt == DCNT_LAST);
  assign capture  = selected && (state == ST_IDLE);
  assign drop     = selected && (state != ST_IDLE);
  assign hs       = tx_valid && tx_ready;
  assign busy     = (state != ST_IDLE);

  // Decimation counter, snapshot and drop counter run independently of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt       <= 16'd0;
      snap       <= 96'd0;
      drop_count <= 16'd0;
    end else begin
      if (in_valid) begin
        dcnt <= (dcnt == DCNT_LAST) ? 16'd0 : dcnt + 16'd1;
      end
      if (capture) begin
        snap <= {x, y, z};
      end
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // State register (FSM state plus the registered output bytes).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bidx     <= 4'd0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
`ifdef LORENZ_FRAME_CSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      state    <= state_nxt;
      bidx     <= bidx_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
`ifdef LORENZ_FRAME_CSUM_EN
      csum     <= csum_nxt;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    bidx_nxt  = bidx;
    case (state)
      ST_IDLE: begin
        if (capture) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        if (hs) begin
          state_nxt = ST_DATA;
          bidx_nxt  = 4'd0;
        end
      end
      ST_DATA: begin
        if (hs) begin
          if (bidx == LAST_BIDX) begin
`ifdef LORENZ_FRAME_CSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_IDLE;
`endif
          end else begin
            bidx_nxt = bidx + 4'd1;
          end
        end
      end
`ifdef LORENZ_FRAME_CSUM_EN
      ST_CSUM: begin
        if (hs) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef LORENZ_FRAME_CSUM_EN
  // Running XOR of data bytes as they are accepted; cleared per frame.
  always_comb begin
    csum_nxt = csum;
    if (capture) begin
      csum_nxt = 8'd0;
    end else if ((state == ST_DATA) && hs) begin
      csum_nxt = csum ^ tx_data;
    end
  end
`endif

  // Output logic: the byte to present after the coming edge is decoded from
  // the next state, so tx_data/tx_valid come straight out of flops. When the
  // sink stalls, the next state and index equal the current ones, so the
  // same byte is re-selected and tx_data stays stable.
  always_comb begin
    snap_shift   = snap << {bidx_nxt, 3'b000};
    tx_valid_nxt = (state_nxt != ST_IDLE);
    tx_data_nxt  = 8'd0;
    case (state_nxt)
      ST_SYNC: tx_data_nxt = SYNC_BYTE;
      ST_DATA: tx_data_nxt = snap_shift[95:88];
`ifdef LORENZ_FRAME_CSUM_EN
      ST_CSUM: tx_data_nxt = csum_nxt;
`endif
      default: tx_data_nxt = 8'd0;
    endcase
  end

endmodule
